// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 window generator.
package conv_pkg;

    localparam int unsigned WIN_SIZE           = 3;
    localparam int unsigned DATA_WIDTH_DEFAULT = 4;

    typedef enum logic {
        S_FILL,
        S_RUN
    } win_state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One-row line buffer: combinational read of the old value, registered write at the same address.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [IMG_WIDTH];

    // Contents are never reset; the frame fill overwrites them before use.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (valid-mode, no padding) over a raster pixel stream.
// Define CONV_WIN_COORD_EN to add the o_win_row / o_win_col output-map coordinate ports.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst_n,
    input  logic                                              i_pix_valid,
    input  logic [DATA_WIDTH-1:0]                             i_pix,
    output logic                                              o_pix_ready,
    output logic                                              o_win_valid,
    output logic [0:WIN_SIZE-1][0:WIN_SIZE-1][DATA_WIDTH-1:0] o_window,
    output logic                                              o_win_last,
`ifdef CONV_WIN_COORD_EN
    output logic [$clog2(IMG_HEIGHT)-1:0]                     o_win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]                      o_win_col,
`endif
    input  logic                                              i_win_ready
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    win_state_t                                        r_state;
    logic [CW-1:0]                                     r_col;
    logic [RW-1:0]                                     r_row;
    logic                                              r_win_valid;
    logic                                              r_win_last;
    logic [0:WIN_SIZE-1][0:WIN_SIZE-1][DATA_WIDTH-1:0] r_window;
`ifdef CONV_WIN_COORD_EN
    logic [RW-1:0]                                     r_win_row;
    logic [CW-1:0]                                     r_win_col;
`endif

    logic                  w_accept;
    logic                  w_col_end;
    logic                  w_frame_end;
    logic                  w_qualify;
    logic [DATA_WIDTH-1:0] w_lb_a_rdata;
    logic [DATA_WIDTH-1:0] w_lb_b_rdata;

    assign o_pix_ready = !r_win_valid || i_win_ready;
    assign w_accept    = i_pix_valid && o_pix_ready;
    assign w_col_end   = (r_col == COL_LAST);
    assign w_frame_end = w_col_end && (r_row == ROW_LAST);
    // S_RUN is exactly r >= 2, so this marks pixels that complete a full window.
    assign w_qualify   = (r_state == S_RUN) && (r_col >= COL_TWO);

    // lb_a holds the previous row, lb_b the one before it.
    conv_line_buffer #(
        .IMG_WIDTH  (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) lb_a (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (i_pix),
        .o_rdata (w_lb_a_rdata)
    );

    conv_line_buffer #(
        .IMG_WIDTH  (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) lb_b (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb_a_rdata),
        .o_rdata (w_lb_b_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_FILL;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_window    <= '0;
`ifdef CONV_WIN_COORD_EN
            r_win_row   <= '0;
            r_win_col   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                if (w_col_end) begin
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end
                for (int i = 0; i < WIN_SIZE; i++) begin
                    for (int j = 0; j < WIN_SIZE - 1; j++) begin
                        r_window[i][j] <= r_window[i][j+1];
                    end
                end
                r_window[0][WIN_SIZE-1] <= w_lb_b_rdata;
                r_window[1][WIN_SIZE-1] <= w_lb_a_rdata;
                r_window[2][WIN_SIZE-1] <= i_pix;
                r_win_last <= w_qualify && w_frame_end;
                unique case (r_state)
                    S_FILL: if (w_col_end && (r_row == ROW_ONE)) r_state <= S_RUN;
                    S_RUN:  if (w_frame_end) r_state <= S_FILL;
                endcase
            end

            if (w_accept && w_qualify) begin
                r_win_valid <= 1'b1;
`ifdef CONV_WIN_COORD_EN
                r_win_row   <= r_row - ROW_TWO;
                r_win_col   <= r_col - COL_TWO;
`endif
            end else if (i_win_ready) begin
                r_win_valid <= 1'b0;
                r_win_last  <= 1'b0;
            end
        end
    end

    assign o_win_valid = r_win_valid;
    assign o_win_last  = r_win_last;
    assign o_window    = r_window;
`ifdef CONV_WIN_COORD_EN
    assign o_win_row   = r_win_row;
    assign o_win_col   = r_win_col;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: window-slice reference model plus directed vector table.
module tb_conv_window_gen;

    localparam int DW  = 4;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int NPF = W * H;

    typedef logic [0:2][0:2][DW-1:0] win_t;

    typedef struct {
        win_t       win;
        logic       last;
        logic [2:0] row;
        logic [2:0] col;
    } exp_t;

    typedef struct {
        int   idx;
        win_t win;
        logic last;
    } vec_t;

    logic          clk;
    logic          i_rst_n;
    logic          i_pix_valid;
    logic [DW-1:0] i_pix;
    logic          o_pix_ready;
    logic          o_win_valid;
    win_t          o_window;
    logic          o_win_last;
    logic          i_win_ready;
`ifdef CONV_WIN_COORD_EN
    logic [2:0]    o_win_row;
    logic [2:0]    o_win_col;
`endif

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_pix_valid (i_pix_valid),
        .i_pix       (i_pix),
        .o_pix_ready (o_pix_ready),
        .o_win_valid (o_win_valid),
        .o_window    (o_window),
        .o_win_last  (o_win_last),
`ifdef CONV_WIN_COORD_EN
        .o_win_row   (o_win_row),
        .o_win_col   (o_win_col),
`endif
        .i_win_ready (i_win_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          q[$];
    logic [DW-1:0] fr [H][W];
    int            pos;
    logic [DW-1:0] src[$];
    int            dut_win;
    int            dut_last;
    win_t          cap_win[$];
    logic          cap_last[$];
    vec_t          tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        dut_win  = 0;
        dut_last = 0;
        cap_win.delete();
        cap_last.delete();
    endtask

    // Called #1 after a negedge: checks outputs, then advances the model past the next posedge.
    task automatic sample(output bit acc);
        bit   take;
        exp_t e;
        int   r, c;
        chk("win_valid", 64'(o_win_valid), 64'(q.size() > 0));
        chk("pix_ready", 64'(o_pix_ready), 64'(q.size() == 0 || i_win_ready));
        if (q.size() > 0) begin
            chk("window", 64'(o_window), 64'(q[0].win));
            chk("win_last", 64'(o_win_last), 64'(q[0].last));
`ifdef CONV_WIN_COORD_EN
            chk("win_row", 64'(o_win_row), 64'(q[0].row));
            chk("win_col", 64'(o_win_col), 64'(q[0].col));
`endif
        end
        acc  = i_pix_valid && (q.size() == 0 || i_win_ready);
        take = (q.size() > 0) && i_win_ready;
        if (o_win_valid && i_win_ready) begin
            dut_win++;
            if (o_win_last) dut_last++;
            cap_win.push_back(o_window);
            cap_last.push_back(o_win_last);
        end
        if (take) void'(q.pop_front());
        if (acc) begin
            r = pos / W;
            c = pos % W;
            fr[r][c] = i_pix;
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[i][j] = fr[r-2+i][c-2+j];
                e.last = (r == H - 1) && (c == W - 1);
                e.row  = 3'(r - 2);
                e.col  = 3'(c - 2);
                q.push_back(e);
            end
            pos = (pos + 1) % NPF;
        end
    endtask

    // vmode: 0 = continuous, 1 = random gaps. rmode: 0 = ready high, 1 = random, 2 = 5-cycle stall.
    task automatic run_stream(input int npix, input int vmode, input int rmode, input bit drain);
        int sent    = 0;
        int cyc     = 0;
        int bp_left = 5;
        bit bp_on   = 0;
        bit acc;
        while ((sent < npix || (drain && q.size() > 0)) && cyc < 4000) begin
            i_pix_valid = (sent < npix) && (vmode == 0 || $urandom_range(1, 0) == 1);
            i_pix       = (sent < npix) ? src[sent] : '0;
            case (rmode)
                1: i_win_ready = ($urandom_range(1, 0) == 1);
                2: begin
                    if (!bp_on && q.size() > 0) bp_on = 1;
                    if (bp_on && bp_left > 0) begin
                        i_win_ready = 1'b0;
                        bp_left--;
                    end else begin
                        i_win_ready = 1'b1;
                    end
                end
                default: i_win_ready = 1'b1;
            endcase
            #1;
            sample(acc);
            if (acc) sent++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: sent %0d of %0d, pending %0d", sent, npix, q.size());
        end
        i_pix_valid = 1'b0;
        i_win_ready = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        i_rst_n     = 1'b0;
        i_pix_valid = 1'b0;
        i_win_ready = 1'b1;
        #1;
        chk("rst_valid", 64'(o_win_valid), 64'(0));
        chk("rst_last", 64'(o_win_last), 64'(0));
        chk("rst_window", 64'(o_window), 64'(0));
`ifdef CONV_WIN_COORD_EN
        chk("rst_row", 64'(o_win_row), 64'(0));
        chk("rst_col", 64'(o_win_col), 64'(0));
`endif
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("rst_hold_valid", 64'(o_win_valid), 64'(0));
        end
        i_rst_n = 1'b1;
        q.delete();
        pos = 0;
    endtask

    task automatic fill_ramp(input int frames, input int offset, input int step);
        src.delete();
        for (int f = 0; f < frames; f++)
            for (int p = 0; p < NPF; p++)
                src.push_back(DW'((p + offset + f * step) & 15));
    endtask

    initial begin
        win_t w2;

        tbl[0].idx = 0;  tbl[0].last = 1'b0;
        tbl[0].win = {4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'hA, 4'h0, 4'h1, 4'h2};
        tbl[1].idx = 5;  tbl[1].last = 1'b0;
        tbl[1].win = {4'h5, 4'h6, 4'h7, 4'hD, 4'hE, 4'hF, 4'h5, 4'h6, 4'h7};
        tbl[2].idx = 6;  tbl[2].last = 1'b0;
        tbl[2].win = {4'h8, 4'h9, 4'hA, 4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'hA};
        tbl[3].idx = 35; tbl[3].last = 1'b1;
        tbl[3].win = {4'hD, 4'hE, 4'hF, 4'h5, 4'h6, 4'h7, 4'hD, 4'hE, 4'hF};

        i_rst_n     = 1'b1;
        i_pix_valid = 1'b0;
        i_pix       = '0;
        i_win_ready = 1'b1;
        pos         = 0;
        @(negedge clk);
        do_reset(2);

        // Plain ramp frame.
        clear_counts();
        fill_ramp(1, 0, 0);
        run_stream(NPF, 0, 0, 1);
        chk("ramp_count", 64'(dut_win), 64'(36));
        chk("ramp_lasts", 64'(dut_last), 64'(1));
        for (int k = 0; k < 4; k++) begin
            chk("tbl_win", (tbl[k].idx < cap_win.size()) ? 64'(cap_win[tbl[k].idx]) : 64'hx,
                64'(tbl[k].win));
            chk("tbl_last", (tbl[k].idx < cap_last.size()) ? 64'(cap_last[tbl[k].idx]) : 64'hx,
                64'(tbl[k].last));
        end

        // Five-cycle backpressure after the first window.
        clear_counts();
        fill_ramp(1, 5, 0);
        run_stream(NPF, 0, 2, 1);
        chk("bp_count", 64'(dut_win), 64'(36));
        chk("bp_lasts", 64'(dut_last), 64'(1));

        // Random pixels, random valid gaps and random ready.
        clear_counts();
        src.delete();
        for (int p = 0; p < 2 * NPF; p++) src.push_back(DW'($urandom_range(15, 0)));
        run_stream(2 * NPF, 1, 1, 1);
        chk("rand_count", 64'(dut_win), 64'(72));
        chk("rand_lasts", 64'(dut_last), 64'(2));

        // Two back-to-back ramp frames with distinct offsets.
        clear_counts();
        fill_ramp(2, 0, 7);
        run_stream(2 * NPF, 0, 0, 1);
        chk("b2b_count", 64'(dut_win), 64'(72));
        chk("b2b_lasts", 64'(dut_last), 64'(2));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w2[i][j] = DW'((i * 8 + j + 7) & 15);
        chk("b2b_first_f2", (cap_win.size() > 36) ? 64'(cap_win[36]) : 64'hx, 64'(w2));

        // Reset mid row 4 with a window still pending, then a fresh frame.
        clear_counts();
        fill_ramp(1, 0, 0);
        run_stream(4 * W + 3, 0, 0, 0);
        do_reset(2);
        clear_counts();
        fill_ramp(1, 3, 0);
        run_stream(NPF, 0, 0, 1);
        chk("post_rst_count", 64'(dut_win), 64'(36));
        chk("post_rst_lasts", 64'(dut_last), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
